alu_seq: RTL
============

Name: alu_seq

Overview:
- Clocked, parametrised successor of the combinational four-function ALU.
- Same operation set and select encoding: add, subtract, multiply, divide. Operand width is generic.
- Multiply and divide are iterative (one bit per cycle) so the block scales to wide operands without a large combinational array.
- Sits between the operand/select source and the result consumer, using a start/done handshake.

Parameters:
- WIDTH, 8, operand width in bits (≥2); result is 2*WIDTH bits.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- start  input  1  request; accepted only when busy=0.
- sel  input  2  operation: 0 add, 1 subtract, 2 multiply, 3 divide.
- num1  input  WIDTH  operand A, unsigned.
- num2  input  WIDTH  operand B, unsigned.
- busy  output  1  high from the accept edge until the edge ending the done cycle.
- done  output  1  one-cycle pulse; result valid.
- result  output  2*WIDTH  operation result, held until the next accepted start.
- div_by_zero  output  1  set with done when sel=3 and num2=0; cleared on the next accept.

Behaviour:
- Clock and reset: one clock. Reset is asynchronous, active-low (reset_n), fixed.
- Reset values: busy=0, done=0, result=0, div_by_zero=0, FSM=IDLE, iteration counter=0.
- FSM states: IDLE, RUN, DONE.
- IDLE, start=1 at edge k: latch num1, num2, sel; clear div_by_zero.
  - sel 0/1, or sel 3 with num2=0: compute result at that edge and go to DONE.
  - sel 2, or sel 3 with num2≠0: go to RUN with counter=WIDTH.
- RUN: one iteration per cycle, counter decrements. When counter reaches 0, write result and go to DONE.
- DONE: done=1 for exactly one cycle, then IDLE. start is ignored in DONE; earliest next accept is the edge after DONE.
- start while busy=1: ignored. Operand and sel changes while busy have no effect.
- Latency (done sampled high at edge):
  - add, sub, divide-by-zero: k+1.
  - mul, div: k+WIDTH+1.
- Add: WIDTH+1-bit unsigned sum, zero-extended to 2*WIDTH.
- Sub: WIDTH+1-bit two's-complement num1-num2, sign-extended to 2*WIDTH (negative differences read as negative).
- Mul: unsigned shift-add, LSB first. Product register is 2*WIDTH bits, so no overflow is possible.
- Div: unsigned restoring division, MSB first.
  - result[WIDTH-1:0] = quotient; result[2*WIDTH-1:WIDTH] = remainder.
  - Divide by zero: quotient = all ones, remainder = num1, div_by_zero=1.
- result changes only at the edge entering DONE (or at reset). Intermediate iteration values never appear on result.
- Reset mid-operation (any state): immediate abort, all outputs to reset values. No done pulse for the aborted op.
- sel is fully decoded; all four codes are legal.

Decomposition:
- Package alu_pkg:
  - op constants OP_ADD=2'd0, OP_SUB=2'd1, OP_MUL=2'd2, OP_DIV=2'd3;
  - state typedef alu_state_t {IDLE, RUN, DONE}.
- Sub-module alu_iter_engine (parameter WIDTH): owns the shift/accumulate registers and the counter for mul/div.
  - Interface: load, op, a, b, busy_iter, finish, prod_or_qr.
  - Top alu_seq holds the FSM, the add/sub path, the div-by-zero shortcut, and the result/flag registers.

Test Plan (WIDTH=8):
- Add 200+100, start for one cycle -> done at k+1, result=0x012C, busy low the following cycle.
- Sub 5-10 -> done at k+1, result=0xFFFB. Sub 10-5 -> result=0x0005.
- Mul 255*255 -> done at k+9, result=0xFE01. Mul 0*37 -> result=0x0000 at k+9.
- Div 200/7 -> done at k+9, result=0x041C (r=4, q=28), div_by_zero=0.
- Div 13/0 -> done at k+1, result=0x0DFF, div_by_zero=1. A following add 1+1 -> result=0x0002 and div_by_zero=0.
- Start pulses every cycle during a mul -> only the first accepted.
- reset_n low at cycle 4 of a mul -> all outputs 0 asynchronously, no done. After release, add 3+4 -> 0x0007 at k+1.

Source files
------------

// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the sequential ALU.
//   OP_* constants  : select encoding shared by alu_seq and alu_iter_engine
//   alu_state_t     : top-level control states
package alu_pkg;

  localparam logic [1:0] OP_ADD = 2'd0;
  localparam logic [1:0] OP_SUB = 2'd1;
  localparam logic [1:0] OP_MUL = 2'd2;
  localparam logic [1:0] OP_DIV = 2'd3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } alu_state_t;

endpackage

// File: rtl/alu_iter_engine.sv
// alu_iter_engine: one-bit-per-cycle multiply / divide datapath.
//   clk, reset_n : clock, asynchronous active-low reset
//   load         : capture a, b, op and start WIDTH iterations
//   op           : OP_MUL selects shift-add multiply, anything else restoring divide
//   a, b         : unsigned operands (multiplicand/multiplier or dividend/divisor)
//   busy_iter    : iterations still outstanding
//   finish       : the coming edge performs the last iteration
//   prod_or_qr   : value the registers take at the coming edge;
//                  {product} for multiply, {remainder, quotient} for divide
module alu_iter_engine
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               load,
  input  logic [1:0]         op,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy_iter,
  output logic               finish,
  output logic [2*WIDTH-1:0] prod_or_qr
);

  localparam int CW = $clog2(WIDTH + 1);

  // r_hi/r_lo form one 2*WIDTH shift register:
  //   multiply: r_hi = partial product, r_lo = remaining multiplier bits
  //   divide  : r_hi = partial remainder, r_lo = dividend bits shifting out / quotient bits shifting in
  logic [CW-1:0]    r_cnt;
  logic             r_is_mul;
  logic [WIDTH-1:0] r_m;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;

  logic [WIDTH:0]   w_mul_acc;
  logic [WIDTH:0]   w_div_shift;
  logic [WIDTH-1:0] w_div_diff;
  logic             w_div_ge;
  logic [WIDTH-1:0] w_hi_next;
  logic [WIDTH-1:0] w_lo_next;

  // Multiply step: add multiplicand into the upper half when the current
  // multiplier LSB is set, then shift the whole register right by one.
  assign w_mul_acc = r_lo[0] ? ({1'b0, r_hi} + {1'b0, r_m}) : {1'b0, r_hi};

  // Divide step: bring the next dividend bit into the remainder, subtract
  // the divisor if it fits. The true difference is always below the divisor,
  // so WIDTH bits hold it exactly.
  assign w_div_shift = {r_hi, r_lo[WIDTH-1]};
  assign w_div_ge    = (w_div_shift >= {1'b0, r_m});
  assign w_div_diff  = w_div_shift[WIDTH-1:0] - r_m;

  always_comb begin
    w_hi_next = r_hi;
    w_lo_next = r_lo;
    if (r_is_mul) begin
      w_hi_next = w_mul_acc[WIDTH:1];
      w_lo_next = {w_mul_acc[0], r_lo[WIDTH-1:1]};
    end else begin
      w_hi_next = w_div_ge ? w_div_diff : w_div_shift[WIDTH-1:0];
      w_lo_next = {r_lo[WIDTH-2:0], w_div_ge};
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt    <= '0;
      r_is_mul <= 1'b0;
      r_m      <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
    end else if (load) begin
      r_cnt    <= CW'(WIDTH);
      r_is_mul <= (op == OP_MUL);
      r_m      <= (op == OP_MUL) ? a : b;
      r_hi     <= '0;
      r_lo     <= (op == OP_MUL) ? b : a;
    end else if (r_cnt != '0) begin
      r_hi  <= w_hi_next;
      r_lo  <= w_lo_next;
      r_cnt <= r_cnt - CW'(1);
    end
  end

  assign busy_iter  = (r_cnt != '0);
  assign finish     = (r_cnt == CW'(1));
  // Exposing the next-state value lets the top capture the final answer on
  // the same edge the last iteration happens.
  assign prod_or_qr = {w_hi_next, w_lo_next};

endmodule

// File: rtl/alu_seq.sv
// alu_seq: clocked four-function ALU with start/done handshake.
//   clk, reset_n : clock, asynchronous active-low reset
//   start        : request, accepted only while idle
//   sel          : 0 add, 1 subtract, 2 multiply, 3 divide
//   num1, num2   : unsigned operands
//   busy         : operation in progress (accept edge up to end of done cycle)
//   done         : one-cycle result-valid pulse
//   result       : 2*WIDTH result, held until the next accepted start
//   div_by_zero  : set with done for a divide by zero, cleared on next accept
// Add, subtract and divide-by-zero complete on the accept edge; multiply and
// divide run WIDTH iterations in alu_iter_engine.
module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               start,
  input  logic [1:0]         sel,
  input  logic [WIDTH-1:0]   num1,
  input  logic [WIDTH-1:0]   num2,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] result,
  output logic               div_by_zero
);

  alu_state_t         r_state;
  alu_state_t         w_state_next;
  logic [2*WIDTH-1:0] r_result;
  logic               r_div_by_zero;

  logic               w_div0;
  logic               w_is_fast;
  logic               w_fast_wr;
  logic               w_load;
  logic               w_iter_wr;
  logic               w_busy_iter;
  logic               w_finish;
  logic [2*WIDTH-1:0] w_iter_result;
  logic [WIDTH:0]     w_sum;
  logic [WIDTH:0]     w_diff;
  logic [2*WIDTH-1:0] w_fast_result;

  assign w_div0    = (sel == OP_DIV) && (num2 == '0);
  assign w_is_fast = (sel == OP_ADD) || (sel == OP_SUB) || w_div0;

  assign w_sum  = {1'b0, num1} + {1'b0, num2};
  assign w_diff = {1'b0, num1} - {1'b0, num2};

  always_comb begin
    w_fast_result = '0;
    case (sel)
      OP_ADD:  w_fast_result = {{(WIDTH-1){1'b0}}, w_sum};
      OP_SUB:  w_fast_result = {{(WIDTH-1){w_diff[WIDTH]}}, w_diff};
      // Only a divide by zero reaches here: remainder = dividend, quotient = all ones.
      default: w_fast_result = {num1, {WIDTH{1'b1}}};
    endcase
  end

  alu_iter_engine #(.WIDTH(WIDTH)) u_engine (
    .clk        (clk),
    .reset_n    (reset_n),
    .load       (w_load),
    .op         (sel),
    .a          (num1),
    .b          (num2),
    .busy_iter  (w_busy_iter),
    .finish     (w_finish),
    .prod_or_qr (w_iter_result)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_fast_wr    = 1'b0;
    w_load       = 1'b0;
    w_iter_wr    = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          if (w_is_fast) begin
            w_fast_wr    = 1'b1;
            w_state_next = DONE;
          end else begin
            w_load       = 1'b1;
            w_state_next = RUN;
          end
        end
      end
      RUN: begin
        if (w_finish) begin
          w_iter_wr    = 1'b1;
          w_state_next = DONE;
        end else if (!w_busy_iter) begin
          // Engine idle while we wait on it cannot happen in normal flow;
          // fall back to IDLE rather than hang.
          w_state_next = IDLE;
        end
      end
      DONE:    w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_result      <= '0;
      r_div_by_zero <= 1'b0;
    end else if (w_fast_wr) begin
      r_result      <= w_fast_result;
      r_div_by_zero <= w_div0;
    end else if (w_load) begin
      r_div_by_zero <= 1'b0;
    end else if (w_iter_wr) begin
      r_result      <= w_iter_result;
    end
  end

  assign busy        = (r_state != IDLE);
  assign done        = (r_state == DONE);
  assign result      = r_result;
  assign div_by_zero = r_div_by_zero;

endmodule
